// File: rtl/sort_stream_bridge.sv
// Byte-stream front end for the 4-entry byte sorter: packs four input bytes into a
// frame, runs one start/done exchange with the sorter, then streams the sorted bytes out.
module sort_stream_bridge #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sort_start,
  output logic [DATA_W-1:0] sort_data_0,
  output logic [DATA_W-1:0] sort_data_1,
  output logic [DATA_W-1:0] sort_data_2,
  output logic [DATA_W-1:0] sort_data_3,
  input  logic              sort_done,
  input  logic [DATA_W-1:0] sort_result_0,
  input  logic [DATA_W-1:0] sort_result_1,
  input  logic [DATA_W-1:0] sort_result_2,
  input  logic [DATA_W-1:0] sort_result_3,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        frame_cnt
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_COLLECT, S_ISSUE, S_WAIT, S_EMIT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] frame_q [4];
  logic [DATA_W-1:0] frame_d [4];
  logic [DATA_W-1:0] buf_q [4];
  logic [DATA_W-1:0] buf_d [4];
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              done_q;
  logic              done_rise;

  // Only a fresh 0->1 of the done level counts; a level left over from the last frame is ignored.
  assign done_rise = sort_done && !done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_COLLECT;
      idx_q         <= '0;
      frame_q       <= '{default: '0};
      buf_q         <= '{default: '0};
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      buf_q         <= buf_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
      frame_cnt_q   <= frame_cnt_d;
      done_q        <= sort_done;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (in_valid && idx_q == 2'd3) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (done_rise)             state_d = S_EMIT;
        else if (tmo_q == TMO_LAST) state_d = S_COLLECT;
      end
      S_EMIT:    if (out_ready && idx_q == 2'd3) state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    idx_d         = idx_q;
    frame_d       = frame_q;
    buf_d         = buf_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    frame_cnt_d   = frame_cnt_q;
    unique case (state_q)
      S_COLLECT: begin
        if (in_valid) begin
          frame_d[idx_q] = in_data;
          idx_d          = idx_q + 2'd1;
        end
      end
      S_ISSUE: tmo_d = '0;
      S_WAIT: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (done_rise) begin
          buf_d = '{sort_result_0, sort_result_1, sort_result_2, sort_result_3};
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    in_ready    = (state_q == S_COLLECT);
    sort_start  = (state_q == S_ISSUE);
    out_valid   = (state_q == S_EMIT);
    out_data    = '0;
    out_last    = 1'b0;
    if (state_q == S_EMIT) begin
      out_data = buf_q[idx_q];
      out_last = (idx_q == 2'd3);
    end
    busy        = (state_q != S_COLLECT) || (idx_q != 2'd0);
    sort_data_0 = frame_q[0];
    sort_data_1 = frame_q[1];
    sort_data_2 = frame_q[2];
    sort_data_3 = frame_q[3];
    timeout_err = timeout_err_q;
    frame_cnt   = frame_cnt_q;
  end

endmodule

// File: tb/tb_sort_stream_bridge.sv
// Bench for sort_stream_bridge: behavioural sorter responder, table-driven frames,
// hand-written corner sequences and a randomized run against a queue-based model.
module tb_sort_stream_bridge;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 32;
  localparam int RND_FRAMES = 260;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       sort_start;
  logic [7:0] sort_data_0, sort_data_1, sort_data_2, sort_data_3;
  logic       sort_done;
  logic [7:0] sort_result_0, sort_result_1, sort_result_2, sort_result_3;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       timeout_err;
  logic [7:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sort_stream_bridge #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sort_start(sort_start),
    .sort_data_0(sort_data_0), .sort_data_1(sort_data_1),
    .sort_data_2(sort_data_2), .sort_data_3(sort_data_3),
    .sort_done(sort_done),
    .sort_result_0(sort_result_0), .sort_result_1(sort_result_1),
    .sort_result_2(sort_result_2), .sort_result_3(sort_result_3),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  function automatic logic [31:0] sort4(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) a[i] = w[8*i +: 8];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return {a[3], a[2], a[1], a[0]};
  endfunction

  // Sorter responder: samples data the cycle after start, drops done then, raises it after srt_lat cycles.
  logic [31:0] srt_res;
  logic        srt_done;
  logic [1:0]  srt_phase;
  int          srt_cnt;
  int          srt_lat = 2;
  bit          srt_dead = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      srt_done  <= 1'b0;
      srt_phase <= 2'd0;
      srt_cnt   <= 0;
      srt_res   <= '0;
    end else if (sort_start) begin
      srt_phase <= 2'd1;
    end else if (srt_phase == 2'd1) begin
      srt_done  <= 1'b0;
      srt_res   <= sort4({sort_data_3, sort_data_2, sort_data_1, sort_data_0});
      srt_cnt   <= srt_lat;
      srt_phase <= 2'd2;
    end else if (srt_phase == 2'd2) begin
      if (srt_cnt == 0) begin
        srt_done  <= !srt_dead;
        srt_phase <= 2'd0;
      end else begin
        srt_cnt <= srt_cnt - 1;
      end
    end
  end

  assign sort_done     = srt_done;
  assign sort_result_0 = srt_res[7:0];
  assign sort_result_1 = srt_res[15:8];
  assign sort_result_2 = srt_res[23:16];
  assign sort_result_3 = srt_res[31:24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Called at a negedge; presents one byte and returns at the negedge after it is taken.
  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      fail_now("push_byte");
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect_frame(output logic [31:0] got, input int stall_idx, input int stall_cyc);
    int guard = 0;
    logic [7:0] held;
    got = '0;
    out_ready = 1'b1;
    while (!out_valid && guard < 200) begin
      check("in_ready_wait", in_ready, 0);
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      fail_now("out_valid_wait");
      return;
    end
    for (int k = 0; k < 4; k++) begin
      check("out_valid", out_valid, 1);
      check("out_last", out_last, k == 3);
      check("in_ready_emit", in_ready, 0);
      got[8*k +: 8] = out_data;
      if (k == stall_idx) begin
        held = out_data;
        out_ready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, held);
          check("stall_last", out_last, k == 3);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_frame(input logic [31:0] din);
    for (int b = 0; b < 4; b++) push_byte(din[8*b +: 8]);
  endtask

  // Randomized-run scoreboard: accepted bytes grouped by four, sorted, then expected in that order.
  logic [7:0] acc [$];
  logic [7:0] expq [$];
  int acc_total = 0;
  int out_pos = 0;
  int out_frames = 0;
  bit rnd_on = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rnd_on) begin
      if (in_valid && in_ready) begin
        acc.push_back(in_data);
        acc_total++;
        if (acc.size() == 4) begin
          acc.sort();
          foreach (acc[i]) expq.push_back(acc[i]);
          acc.delete();
        end
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) fail_now("rnd_unexpected_output");
        else check("rnd_data", out_data, expq.pop_front());
        check("rnd_last", out_last, out_pos == 3);
        out_pos = (out_pos + 1) % 4;
        if (out_pos == 0) out_frames++;
      end
    end
  end

  typedef struct {
    logic [31:0] din;
    logic [31:0] dexp;
    int          stall_idx;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [31:0] got;
    logic [7:0]  base;
    bit          saw_valid;
    int          guard;

    vecs[0] = '{din: 32'h20401030, dexp: 32'h40302010, stall_idx: -1};
    vecs[1] = '{din: 32'h20401030, dexp: 32'h40302010, stall_idx: 1};
    vecs[2] = '{din: 32'h00FF00FF, dexp: 32'hFFFF0000, stall_idx: -1};
    vecs[3] = '{din: 32'h02030405, dexp: 32'h05040302, stall_idx: -1};
    vecs[4] = '{din: 32'hFE017F80, dexp: 32'hFE807F01, stall_idx: 3};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #7;
    check("rst_in_ready", in_ready, 1);
    check("rst_sort_start", sort_start, 0);
    check("rst_sort_data", {sort_data_3, sort_data_2, sort_data_1, sort_data_0}, 0);
    check("rst_out", {out_valid, out_last, out_data}, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      push_byte(vecs[i].din[7:0]);
      check("busy_partial", busy, 1);
      for (int b = 1; b < 4; b++) push_byte(vecs[i].din[8*b +: 8]);
      check("sort_start_pulse", sort_start, 1);
      @(negedge clk);
      check("sort_start_single", sort_start, 0);
      collect_frame(got, vecs[i].stall_idx, 3);
      check($sformatf("vec%0d_data", i), got, vecs[i].dexp);
      check("vec_frame_cnt", frame_cnt, i + 1);
      check("vec_busy_idle", busy, 0);
      check("vec_sort_data_held", {sort_data_3, sort_data_2, sort_data_1, sort_data_0}, vecs[i].din);
    end

    // Sorter never answers: timeout, no output, then a normal frame.
    srt_dead = 1'b1;
    push_frame(32'h0D0C0B0A);
    check("tmo_sort_start", sort_start, 1);
    saw_valid = 1'b0;
    for (int j = 1; j <= TIMEOUT; j++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("tmo_err_not_early", timeout_err, 0);
    check("tmo_in_ready_early", in_ready, 0);
    @(negedge clk);
    check("tmo_err_set", timeout_err, 1);
    check("tmo_in_ready", in_ready, 1);
    check("tmo_busy", busy, 0);
    check("tmo_no_output", saw_valid, 0);
    check("tmo_frame_cnt", frame_cnt, 5);
    srt_dead = 1'b0;
    push_frame(32'h22331144);
    collect_frame(got, -1, 0);
    check("post_tmo_data", got, 32'h44332211);
    check("post_tmo_err_sticky", timeout_err, 1);
    check("post_tmo_frame_cnt", frame_cnt, 6);

    // Source keeps offering 0x77 through WAIT/EMIT; it must become byte 0 of the next frame.
    push_frame(32'h80706050);
    in_valid = 1'b1;
    in_data  = 8'h77;
    collect_frame(got, 2, 2);
    check("hold_frame_data", got, 32'h80706050);
    check("hold_in_ready_back", in_ready, 1);
    check("hold_busy_before", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_busy_after", busy, 1);
    check("hold_byte0", sort_data_0, 8'h77);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    collect_frame(got, -1, 0);
    check("hold_next_data", got, 32'h77030201);
    check("hold_frame_cnt", frame_cnt, 8);

    // Asynchronous reset in the middle of a frame.
    push_byte(8'hAA);
    push_byte(8'hBB);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_sort_data", {sort_data_3, sort_data_2, sort_data_1, sort_data_0}, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_timeout_err", timeout_err, 0);
    check("arst_out", {out_valid, out_last, out_data}, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    push_frame(32'h06070809);
    collect_frame(got, -1, 0);
    check("arst_next_data", got, 32'h09080706);
    check("arst_next_frame_cnt", frame_cnt, 1);

    // Randomized traffic; enough frames to wrap frame_cnt.
    base = frame_cnt;
    rnd_on = 1'b1;
    guard = 0;
    while ((acc_total < RND_FRAMES * 4 || out_frames < RND_FRAMES) && guard < 60000) begin
      @(posedge clk);
      #2;
      in_valid  = (acc_total < RND_FRAMES * 4) && ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      srt_lat   = $urandom_range(0, 5);
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rnd_on = 1'b0;
    if (guard >= 60000) fail_now("rnd_run");
    check("rnd_frames", out_frames, RND_FRAMES);
    check("rnd_queue_empty", expq.size(), 0);
    check("rnd_frame_cnt_wrap", frame_cnt, 8'(base + 8'(RND_FRAMES)));
    check("rnd_busy", busy, 0);
    check("rnd_timeout_err", timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
